// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// control FSM encodings and the default largest n whose factorial fits in 32 bits.
package fact_pkg;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int unsigned FACT_N_MAX = 32'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MULT  = 2'd2,
        ST_ERROR = 2'd3
    } fact_state_e;

endpackage

// File: rtl/fact_cu.sv
// Control unit: state register plus next-state and enable decode.
// Go commands are only honoured in IDLE, which also covers a go on the done edge.
module fact_cu
    import fact_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [1:0] a,
    input  logic       wd0,
    input  logic       cnt_gt1,
    input  logic       n_gt_max,
    output logic       load_en,
    output logic       dec_en,
    output logic       mul_en,
    output logic       commit_en,
    output logic       err_en,
    output logic       busy
);

    fact_state_e state_r;
    fact_state_e state_nxt_s;
    logic        go_s;

    assign go_s = we & (a == ADDR_GO) & wd0;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath enable decode
    always_comb begin
        state_nxt_s = state_r;
        load_en     = 1'b0;
        dec_en      = 1'b0;
        mul_en      = 1'b0;
        commit_en   = 1'b0;
        err_en      = 1'b0;
        busy        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (go_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                if (n_gt_max) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_MULT;
                end
            end
            ST_MULT: begin
                if (cnt_gt1) begin
                    mul_en      = 1'b1;
                    dec_en      = 1'b1;
                    state_nxt_s = ST_MULT;
                end else begin
                    commit_en   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ERROR: begin
                err_en      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fact_dp.sv
// Datapath: operand, counter, running product, result and status flags,
// the 32x4 multiplier, the comparators feeding the control unit and the read mux.
module fact_dp
    import fact_pkg::*;
#(
    parameter int unsigned N_MAX = FACT_N_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [3:0]  wd_n,
    input  logic        busy,
    input  logic        load_en,
    input  logic        dec_en,
    input  logic        mul_en,
    input  logic        commit_en,
    input  logic        err_en,
    output logic        cnt_gt1,
    output logic        n_gt_max,
    output logic [31:0] rd
);

    localparam logic [4:0] NMAX_CMP = 5'(N_MAX);

    logic [3:0]  n_r;
    logic [3:0]  cnt_r;
    logic [31:0] prod_r;
    logic [31:0] result_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] prod_mul_s;

    // Truncation is harmless: N_MAX keeps every valid product within 32 bits
    assign prod_mul_s = prod_r * {28'd0, cnt_r};
    assign cnt_gt1    = (cnt_r > 4'd1);
    assign n_gt_max   = ({1'b0, n_r} > NMAX_CMP);

    // Operand register; frozen while a computation is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            n_r <= 4'd0;
        end else if (we && !busy && (a == ADDR_N)) begin
            n_r <= wd_n;
        end else begin
            n_r <= n_r;
        end
    end

    // Counter and running product
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= 4'd0;
            prod_r <= 32'd0;
        end else if (load_en) begin
            cnt_r  <= n_r;
            prod_r <= 32'd1;
        end else begin
            cnt_r  <= dec_en ? (cnt_r - 4'd1) : cnt_r;
            prod_r <= mul_en ? prod_mul_s : prod_r;
        end
    end

    // Result and status flags, held until the next accepted go
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= 32'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (load_en) begin
            result_r <= result_r;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (commit_en) begin
            result_r <= prod_r;
            done_r   <= 1'b1;
            err_r    <= err_r;
        end else if (err_en) begin
            result_r <= 32'd0;
            done_r   <= 1'b1;
            err_r    <= 1'b1;
        end else begin
            result_r <= result_r;
            done_r   <= done_r;
            err_r    <= err_r;
        end
    end

    // Combinational register read mux
    always_comb begin
        rd = 32'd0;
        case (a)
            ADDR_N:      rd = {28'd0, n_r};
            ADDR_GO:     rd = {31'd0, busy};
            ADDR_STATUS: rd = {30'd0, err_r, done_r};
            ADDR_RESULT: rd = result_r;
            default:     rd = 32'd0;
        endcase
    end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: bus-facing wrapper that only connects
// the control unit and the datapath.
module fact_accel
    import fact_pkg::*;
#(
    parameter int unsigned N_MAX = FACT_N_MAX
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    output logic [31:0] RD
);

    logic load_en_s;
    logic dec_en_s;
    logic mul_en_s;
    logic commit_en_s;
    logic err_en_s;
    logic busy_s;
    logic cnt_gt1_s;
    logic n_gt_max_s;
    logic unused_wd_s;

    // Only WD[3:0] carries state; the rest of the bus word is don't-care
    assign unused_wd_s = ^WD[31:4];

    fact_cu u_cu (
        .clk       (Clk),
        .reset     (reset),
        .we        (we),
        .a         (A),
        .wd0       (WD[0]),
        .cnt_gt1   (cnt_gt1_s),
        .n_gt_max  (n_gt_max_s),
        .load_en   (load_en_s),
        .dec_en    (dec_en_s),
        .mul_en    (mul_en_s),
        .commit_en (commit_en_s),
        .err_en    (err_en_s),
        .busy      (busy_s)
    );

    fact_dp #(
        .N_MAX (N_MAX)
    ) u_dp (
        .clk       (Clk),
        .reset     (reset),
        .we        (we),
        .a         (A),
        .wd_n      (WD[3:0]),
        .busy      (busy_s),
        .load_en   (load_en_s),
        .dec_en    (dec_en_s),
        .mul_en    (mul_en_s),
        .commit_en (commit_en_s),
        .err_en    (err_en_s),
        .cnt_gt1   (cnt_gt1_s),
        .n_gt_max  (n_gt_max_s),
        .rd        (RD)
    );

endmodule

// File: tb/tb_fact_accel.sv
// Directed self-checking bench for fact_accel: register map, edge-exact
// completion timing, error path, ignored writes while busy and mid-run reset.
module tb_fact_accel;

    logic        Clk;
    logic        reset;
    logic        we;
    logic [1:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks;
    int failures;

    fact_accel dut (
        .Clk   (Clk),
        .reset (reset),
        .we    (we),
        .A     (A),
        .WD    (WD),
        .RD    (RD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one write; returns 1ns after the accepting edge
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        we = 1'b1;
        @(posedge Clk);
        #1;
        we = 1'b0;
        WD = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] v);
        A = addr;
        #1;
        v = RD;
    endtask

    // Advance to 1ns after the k-th following edge
    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge Clk);
        end
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_rd[%0d]: got %0h expected 0", i, v);
            end
        end
    endtask

    task automatic test_fact5;
        logic [31:0] v;
        bus_write(2'd0, 32'hABCD_0005);
        bus_read(2'd0, v);
        checks++;
        if (v !== 32'd5) begin
            failures++;
            $display("FAIL n_readback: got %0h expected 5", v);
        end
        bus_write(2'd1, 32'd1);                       // E0
        for (int e = 1; e <= 5; e++) begin
            step(1);
            bus_read(2'd1, v);
            checks++;
            if (v !== 32'd1) begin
                failures++;
                $display("FAIL f5_busy_E%0d: got %0h expected 1", e, v);
            end
            bus_read(2'd2, v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL f5_status_E%0d: got %0h expected 0", e, v);
            end
        end
        step(1);                                      // E6
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("FAIL f5_status_E6: got %0h expected 1", v);
        end
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL f5_busy_E6: got %0h expected 0", v);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h78) begin
            failures++;
            $display("FAIL f5_result: got %0h expected 78", v);
        end
    endtask

    task automatic test_small;
        logic [31:0] v;
        for (int n = 0; n <= 1; n++) begin
            bus_write(2'd0, 32'(n));
            bus_write(2'd1, 32'd1);                   // E0
            step(1);                                  // E1: done cleared by LOAD
            bus_read(2'd2, v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL small%0d_status_E1: got %0h expected 0", n, v);
            end
            step(1);                                  // E2
            bus_read(2'd2, v);
            checks++;
            if (v !== 32'd1) begin
                failures++;
                $display("FAIL small%0d_status_E2: got %0h expected 1", n, v);
            end
            bus_read(2'd3, v);
            checks++;
            if (v !== 32'd1) begin
                failures++;
                $display("FAIL small%0d_result: got %0h expected 1", n, v);
            end
        end
    endtask

    task automatic test_n12_and_err;
        logic [31:0] v;
        bus_write(2'd0, 32'd12);
        bus_write(2'd1, 32'd1);                       // E0
        step(12);                                     // E12
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL n12_status_E12: got %0h expected 0", v);
        end
        step(1);                                      // E13
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd1) begin
            failures++;
            $display("FAIL n12_status_E13: got %0h expected 1", v);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h1C8C_FC00) begin
            failures++;
            $display("FAIL n12_result: got %0h expected 1c8cfc00", v);
        end
        bus_write(2'd0, 32'd13);
        bus_write(2'd1, 32'd1);                       // E0
        step(1);
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL err_status_E1: got %0h expected 0", v);
        end
        step(1);                                      // E2
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd3) begin
            failures++;
            $display("FAIL err_status_E2: got %0h expected 3", v);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL err_result: got %0h expected 0", v);
        end
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL err_busy: got %0h expected 0", v);
        end
    endtask

    task automatic test_busy_writes;
        logic [31:0] v;
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd1);                       // E0
        step(1);                                      // E1
        bus_write(2'd0, 32'd3);                       // accepted edge E2
        bus_write(2'd1, 32'd1);                       // accepted edge E3
        step(3);                                      // E6
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'h78) begin
            failures++;
            $display("FAIL bw_result: got %0h expected 78", v);
        end
        bus_read(2'd0, v);
        checks++;
        if (v !== 32'd5) begin
            failures++;
            $display("FAIL bw_n: got %0h expected 5", v);
        end
        step(1);                                      // E7
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL bw_busy_E7: got %0h expected 0", v);
        end
        // go landing on the done edge (N=2 finishes at E3) must be dropped
        bus_write(2'd0, 32'd2);
        bus_write(2'd1, 32'd1);                       // E0
        step(2);                                      // E2
        bus_write(2'd1, 32'd1);                       // accepted edge E3 = done edge
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL done_edge_busy_E3: got %0h expected 0", v);
        end
        step(1);                                      // E4
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL done_edge_busy_E4: got %0h expected 0", v);
        end
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'd2) begin
            failures++;
            $display("FAIL done_edge_result: got %0h expected 2", v);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        bus_write(2'd0, 32'd7);
        bus_write(2'd1, 32'd1);                       // E0
        step(2);                                      // E2
        reset = 1'b1;
        step(1);                                      // E3
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL midrst_rd[%0d]: got %0h expected 0", i, v);
            end
        end
        step(1);
        bus_read(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midrst_busy_after: got %0h expected 0", v);
        end
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd1);                       // E0
        step(4);                                      // E4
        bus_read(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL n4_status_E4: got %0h expected 0", v);
        end
        step(1);                                      // E5
        bus_read(2'd3, v);
        checks++;
        if (v !== 32'd24) begin
            failures++;
            $display("FAIL n4_result: got %0h expected 18", v);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        we       = 1'b0;
        A        = 2'd0;
        WD       = 32'd0;
        #1;
        test_reset();
        test_fact5();
        test_small();
        test_n12_and_err();
        test_busy_writes();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator: the responder on the processor's data bus, sitting behind the address decoder that produces the `we1`/`we2`/`we3` strobes in `mips_top`. The processor writes an operand and a start command, polls status, and reads back n!. Computation is iterative, one multiply per cycle. The block is split into a control unit and a datapath, matching the processor's cu/dp organisation.

## Interface
- `N_MAX`, 12: largest n whose factorial fits in 32 bits; larger n flags an error.
- `Clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `we` input 1: decoded write strobe for this peripheral, sampled at the rising edge of `Clk`.
- `A` input 2: register select (word offset).
- `WD` input 32: write data.
- `RD` output 32: read data, combinational from `A`.

## Operation
- Register map:
  - `A=0` N: low 4 bits read/write, upper bits read as 0.
  - `A=1` GO: a write with `WD[0]=1` starts a computation. Reads return `{31'b0, busy}`.
  - `A=2` STATUS: reads `{30'b0, err, done}`. Writes are ignored.
  - `A=3` RESULT: read-only 32-bit result.
- Control FSM states:
  - IDLE: `busy=0`. Go write (`we & A==1 & WD[0]`) moves to LOAD.
  - LOAD: `cnt<=N`, `prod<=1`, `done<=0`, `err<=0`. If `N>N_MAX`, go to ERROR, otherwise go to MULT.
  - MULT: if `cnt>1`, then `prod<=prod*cnt` (low 32 bits) and `cnt<=cnt-1`, staying in MULT. Otherwise `result<=prod`, `done<=1`, and return to IDLE.
  - ERROR: `err<=1`, `done<=1`, `result<=0`, then return to IDLE.
- `busy=1` in LOAD, MULT and ERROR.
- Writes to N or GO while busy are ignored. N is frozen during a computation.
- `done`, `err` and `result` hold their values until the next accepted go.
- 0! = 1! = 1.
- Arithmetic: 4-bit `cnt`, 32-bit `prod`. The multiply is 32×4 truncated to 32 bits. The `N_MAX` check ensures truncation never happens for a valid result.

## Timing
- Reset values: N=0, `cnt=0`, `prod=0`, `result=0`, `done=0`, `err=0`, state=IDLE. As a result `RD=0` for every `A` after reset.
- The edge that accepts the go write is E0. LOAD executes at E1.
- For `N≤N_MAX`, `done` becomes 1 and `result` becomes valid at edge E(max(N,1)+1).
  - Example: N=5 gives done at E6.
  - Worst case N=12 gives done at E13.
- For `N>N_MAX`, `err=done=1` at E2.
- `busy` is 1 from after E0 until the edge where `done` rises. It reads 0 in the cycle immediately after that edge.
- Simultaneous events:
  - A go write in the same cycle that `done` rises is ignored, because the state is not yet IDLE.
  - A write of N in the same cycle as go (impossible on a single-port bus) needs no handling.
- `reset` asserted in any state returns everything to reset values at that edge. No partial result survives.
- `RD` is purely combinational. A read of STATUS in the cycle after the done edge sees `done=1`.

## Structure
- Shared package `fact_pkg`:
  - register offsets `ADDR_N`, `ADDR_GO`, `ADDR_STATUS`, `ADDR_RESULT`
  - FSM state encodings for IDLE, LOAD, MULT, ERROR
  - default `N_MAX`
- Sub-modules:
  - `fact_cu`: state register plus next-state/control decode. Outputs load/decrement/multiply/commit/error enables and `busy`.
  - `fact_dp`: N, `cnt`, `prod`, `result`, `done` and `err` registers, the multiplier, the `cnt>1` and `N>N_MAX` comparators, and the read mux.
- `fact_accel` only instantiates and connects these two.

## Test plan
- Reset, then read all four addresses → every `RD` equals 0.
- Write N=5, go at E0, then poll → `busy=1` through E5, `done=1` at E6, RESULT = 120 (0x78), `err=0`.
- N=0 and N=1 → `done` at E2, RESULT = 1 in both cases.
- N=12 → `done` at E13, RESULT = 479001600 (0x1C8CFC00). Then N=13 → STATUS = 0b11 at E2, RESULT = 0.
- N=5 and go, then write N=3 and another go at E2 → both ignored. RESULT = 120 at E6, and reading N returns 5.
- N=7 and go, assert `reset` at E3 → at E4 everything reads 0 and state is IDLE. A subsequent N=4 and go gives RESULT = 24 at E5.
